// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit_pkg
// Purpose : Shared op encodings and FSM state encodings for the mul/div unit
// Rev     : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

  // Op encodings, shared with the decoder/control that drives op
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FIX   = 2'd2;

  function automatic logic is_signed_op(input logic [1:0] op_v);
    return (op_v == OP_MULT) || (op_v == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_datapath
// Purpose : Shift-add multiply / restoring divide step on a 2*WIDTH accumulator
// Rev     : 1.0  initial release
// ============================================================================
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;

  // Multiply keeps the multiplier in the low half; divide keeps the dividend there
  always_comb begin
    w_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    w_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, m_q};
    acc_d    = acc_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    if (load_i) begin
      is_div_d = is_div_i;
      if (is_div_i) begin
        acc_d = {{WIDTH{1'b0}}, a_i};
        m_d   = b_i;
      end else begin
        acc_d = {{WIDTH{1'b0}}, b_i};
        m_d   = a_i;
      end
    end else if (step_i) begin
      if (is_div_q) begin
        if (!w_diff[WIDTH]) acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                acc_d = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {w_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Purpose : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Rev     : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_unit_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_orig_q, a_orig_d;
  logic               done_q, done_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d, div0_q, div0_d;
  logic               w_start, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_acc, w_prod;

  assign w_start = start && (state_q == ST_IDLE);
  assign w_a_neg = is_signed_op(op) && rs_data[WIDTH-1];
  assign w_b_neg = is_signed_op(op) && rt_data[WIDTH-1];
  assign w_a_mag = w_a_neg ? -rs_data : rs_data;
  assign w_b_mag = w_b_neg ? -rt_data : rt_data;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load_i   (w_start),
    .step_i   (state_q == ST_RUN),
    .is_div_i (op[1]),
    .a_i      (w_a_mag),
    .b_i      (w_b_mag),
    .acc_o    (w_acc)
  );

  assign w_prod = neg_res_q ? -w_acc : w_acc;
  assign w_quo  = neg_res_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = neg_rem_q ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_orig_d  = a_orig_q;
    done_d    = 1'b0;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          neg_res_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          is_div_d  = op[1];
          div0_d    = (rt_data == '0);
          a_orig_d  = rs_data;
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        // Divide by zero reports all-ones quotient and the untouched dividend
        if (!is_div_q) begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = w_rem;
          lo_d = w_quo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_orig_q  <= '0;
      done_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_orig_q  <= a_orig_d;
      done_q    <= done_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
